// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle datapath controller with memory-wait timeout and sticky fault
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCondEQ,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic [3:0] State,
  output logic       Retire,
  output logic       Fault
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXEC_I    = 4'd10,
    I_WB      = 4'd11,
    FAULT     = 4'd15
  } state_t;

  state_t     state, nextState;
  logic [7:0] waitCnt, nextCnt;
  logic       memState, timeout;
  logic [2:0] immOp;

  assign memState = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign timeout  = memState && !MemReady && (waitCnt == 8'(MEM_TIMEOUT));
  assign immOp    = (OP == 6'h0C) ? 3'b100 : (OP == 6'h0D) ? 3'b011 : (OP == 6'h0F) ? 3'b101 : 3'b000;
  assign State    = state;

  // State and wait counter registers; reset discards any partial operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      waitCnt <= 8'd0;
    end else begin
      state   <= nextState;
      waitCnt <= nextCnt;
    end
  end

  // Next state; MemReady wins over the timeout in the same cycle
  always_comb begin
    nextState = state;
    case (state)
      FETCH:     nextState = MemReady ? DECODE : timeout ? FAULT : FETCH;
      DECODE: begin
        case (OP)
          6'h00:                      nextState = EXEC_R;
          6'h23, 6'h2B:               nextState = MEM_ADDR;
          6'h04, 6'h05:               nextState = BRANCH;
          6'h02:                      nextState = JUMP;
          6'h08, 6'h0C, 6'h0D, 6'h0F: nextState = EXEC_I;
          default:                    nextState = FAULT;
        endcase
      end
      MEM_ADDR:  nextState = (OP == 6'h23) ? MEM_READ : MEM_WRITE;
      MEM_READ:  nextState = MemReady ? MEM_WB : timeout ? FAULT : MEM_READ;
      MEM_WB:    nextState = FETCH;
      MEM_WRITE: nextState = MemReady ? FETCH : timeout ? FAULT : MEM_WRITE;
      EXEC_R:    nextState = R_WB;
      R_WB:      nextState = FETCH;
      BRANCH:    nextState = FETCH;
      JUMP:      nextState = FETCH;
      EXEC_I:    nextState = I_WB;
      I_WB:      nextState = FETCH;
      FAULT:     nextState = FAULT;
      default:   nextState = FAULT;
    endcase
    nextCnt = (nextState != state) ? 8'd0 : (memState && !MemReady) ? waitCnt + 8'd1 : waitCnt;
  end

  // Decoded outputs; everything is forced low while reset is held
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALUOp         = 3'b000;
    Retire        = 1'b0;
    Fault         = 1'b0;
    if (reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        DECODE:    ALUSrcB = 2'b11;
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_READ: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          Retire   = 1'b1;
        end
        MEM_WRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          Retire   = MemReady;
        end
        EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          Retire   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA       = 1'b1;
          ALUOp         = 3'b001;
          PCSource      = 2'b01;
          PCWriteCondEQ = (OP == 6'h04);
          PCWriteCondNE = (OP == 6'h05);
          Retire        = 1'b1;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          Retire   = 1'b1;
        end
        EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = immOp;
        end
        I_WB: begin
          RegWrite = 1'b1;
          Retire   = 1'b1;
          ALUOp    = immOp;
        end
        FAULT:     Fault = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
